// File: rtl/cipher_pkg.sv
// Shared types for the chained-XOR stream cipher tile.
package cipher_pkg;

  // Engine state: IDLE until the first seed arrives, then RUN forever (until rst).
  typedef enum logic {ST_IDLE, ST_RUN} cs_state_e;

  // Per-beat direction of the input word.
  typedef enum logic {MODE_ENC, MODE_DEC} cs_mode_e;

endpackage

// File: rtl/chain_history.sv
// Ciphertext history: newest-first shift register with fill count, overflow
// flag and a combinational readback that can recover the plaintext of an
// entry by XORing it with its predecessor (older entry or the seed).
module chain_history
  import cipher_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] seed_value,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_sel,
  output logic [IDX_W:0]    count,
  output logic              wrapped,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_lost
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] hist_reg  [DEPTH];
  logic [DATA_W-1:0] hist_next [DEPTH];
  logic [IDX_W:0]    count_reg;
  logic              wrapped_reg;

  // Slot 0 takes the new word; every other slot takes its younger neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign hist_next[gi] = push_data;
      end else begin : g_tail
        assign hist_next[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  // History storage: cleared on seed, shifted on every pushed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_reg[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) hist_reg[i] <= '0;
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++) hist_reg[i] <= hist_next[i];
    end
  end

  // Fill level saturates at DEPTH; pushing into a full history loses the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else if (clear) begin
      count_reg   <= '0;
      wrapped_reg <= 1'b0;
    end else if (push) begin
      if (count_reg == FULL_COUNT) wrapped_reg <= 1'b1;
      else                         count_reg   <= count_reg + 1'b1;
    end
  end

  assign count   = count_reg;
  assign wrapped = wrapped_reg;

  logic [IDX_W:0]   idx_ext;
  logic [IDX_W:0]   idx_next_ext;
  logic [IDX_W-1:0] idx_next;

  assign idx_ext      = {1'b0, rd_idx};
  assign idx_next_ext = idx_ext + {{IDX_W{1'b0}}, 1'b1};
  // Only used when idx_next_ext < count, so truncation never aliases.
  assign idx_next     = idx_next_ext[IDX_W-1:0];

  // Readback: the oldest entry's predecessor is the seed until anything is dropped.
  always_comb begin
    rd_data = '0;
    rd_lost = 1'b0;
    if (idx_ext >= count_reg) begin
      rd_lost = 1'b1;
    end else if (!rd_sel) begin
      rd_data = hist_reg[rd_idx];
    end else if (idx_next_ext < count_reg) begin
      rd_data = hist_reg[rd_idx] ^ hist_reg[idx_next];
    end else if (!wrapped_reg) begin
      rd_data = hist_reg[rd_idx] ^ seed_value;
    end else begin
      rd_lost = 1'b1;
    end
  end

endmodule

// File: rtl/chain_cipher_stream.sv
// Chained-XOR stream cipher engine: each word is combined with the previous
// ciphertext (seed for the first), results leave through a one-deep output
// register with valid/ready, and a history block keeps recent ciphertext.
module chain_cipher_stream
  import cipher_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [DATA_W-1:0] seed,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W:0]    count,
  output logic              wrapped,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_lost
);

  cs_state_e         state_reg;
  logic [DATA_W-1:0] chain_reg;
  logic [DATA_W-1:0] seed_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;

  cs_mode_e          beat_mode;
  logic              accept;
  logic [DATA_W-1:0] cipher_word;
  logic [DATA_W-1:0] result_word;

  // A stalled output blocks input so the held word is never overwritten;
  // a seed load in the same cycle wins over any offered word.
  assign in_ready = (state_reg == ST_RUN) && !seed_load && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  assign beat_mode   = cs_mode_e'(mode);
  // The chain always advances on ciphertext, whichever direction the beat runs.
  assign cipher_word = (beat_mode == MODE_ENC) ? (in_data ^ chain_reg) : in_data;
  assign result_word = (beat_mode == MODE_ENC) ? cipher_word : (in_data ^ chain_reg);

  // Control FSM, chain register and output register updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      chain_reg     <= '0;
      seed_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (seed_load) begin
      state_reg     <= ST_RUN;
      chain_reg     <= seed;
      seed_reg      <= seed;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      chain_reg     <= cipher_word;
      out_data_reg  <= result_word;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  chain_history #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_history (
    .clk        (clk),
    .rst        (rst),
    .clear      (seed_load),
    .push       (accept),
    .push_data  (cipher_word),
    .seed_value (seed_reg),
    .rd_idx     (rd_idx),
    .rd_sel     (rd_sel),
    .count      (count),
    .wrapped    (wrapped),
    .rd_data    (rd_data),
    .rd_lost    (rd_lost)
  );

endmodule

// File: tb/tb_chain_cipher_stream.sv
// Bench for chain_cipher_stream: directed scenarios plus a randomized run
// against a model that tracks the full plaintext/ciphertext streams.
module tb_chain_cipher_stream;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              seed_load;
  logic [DATA_W-1:0] seed;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W:0]    count;
  logic              wrapped;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              rd_lost;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: every cipher word and its plaintext since the last seed.
  logic [7:0] m_seed;
  logic [7:0] m_ct[$];
  logic [7:0] m_pt[$];
  logic [7:0] m_exp[$];
  bit         m_run = 1'b0;

  always #5 clk = ~clk;

  chain_cipher_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .wrapped(wrapped), .rd_idx(rd_idx), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_lost(rd_lost)
  );

  function automatic logic [7:0] model_prev();
    if (m_ct.size() != 0) return m_ct[m_ct.size()-1];
    return m_seed;
  endfunction

  function automatic void model_reseed(input logic [7:0] s);
    m_seed = s;
    m_ct.delete();
    m_pt.delete();
    m_exp.delete();
    m_run = 1'b1;
  endfunction

  function automatic void model_accept(input logic [7:0] d, input bit md);
    logic [7:0] prev;
    logic [7:0] c;
    logic [7:0] p;
    prev = model_prev();
    if (!md) begin c = d ^ prev; p = d; m_exp.push_back(c); end
    else     begin c = d; p = d ^ prev; m_exp.push_back(p); end
    m_ct.push_back(c);
    m_pt.push_back(p);
    $display("beat %0d mode=%0d in=%02h plain=%02h cipher=%02h", m_ct.size(), md, d, p, c);
  endfunction

  function automatic int model_count();
    return (m_ct.size() < DEPTH) ? m_ct.size() : DEPTH;
  endfunction

  function automatic bit model_wrapped();
    return m_ct.size() > DEPTH;
  endfunction

  // Newest is index 0; a plain word is recoverable if its predecessor is still known.
  function automatic void model_read(input int idx, input bit sel,
                                     output logic [7:0] d, output bit lost);
    int n;
    int k;
    n = m_ct.size();
    d = 8'h00;
    lost = 1'b0;
    if (idx >= model_count()) begin
      lost = 1'b1;
    end else begin
      k = n - 1 - idx;
      if (!sel)                       d = m_ct[k];
      else if (idx + 1 < model_count()) d = m_pt[k];
      else if (!model_wrapped())      d = m_pt[k];
      else                            lost = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [7:0] s);
    seed = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    model_reseed(s);
  endtask

  task automatic send(input logic [7:0] d, input bit md, output bit acc);
    in_valid = 1'b1;
    in_data = d;
    mode = md;
    #1;
    acc = in_ready;
    if (out_valid && out_ready && m_exp.size() != 0) void'(m_exp.pop_front());
    if (acc) model_accept(d, md);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; seed_load = 1'b0; seed = '0; mode = 1'b0; in_valid = 1'b1;
    in_data = 8'hAA; out_ready = 1'b1; rd_idx = '0; rd_sel = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %02h want 00", out_data); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped got %0b want 0", wrapped); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    n_checks++; if (rd_data !== 8'h00 || rd_lost !== 1'b1) begin n_fail++; $display("FAIL reset_readback got %02h/%0b want 00/1", rd_data, rd_lost); end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got %0b want 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_vectors();
    bit acc;
    out_ready = 1'b1;
    do_seed(8'h00);
    send(8'h41, 1'b0, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL vec_accept1 got %0b want 1", acc); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_fail++; $display("FAIL vec_out1 got %0b/%02h want 1/41", out_valid, out_data); end
    send(8'h42, 1'b0, acc);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin n_fail++; $display("FAIL vec_out2 got %0b/%02h want 1/03", out_valid, out_data); end
    void'(m_exp.pop_front());
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_retire got %0b want 0", out_valid); end
    rd_idx = 3'd0; rd_sel = 1'b0; #1;
    n_checks++; if (rd_data !== 8'h03 || rd_lost !== 1'b0) begin n_fail++; $display("FAIL vec_rd0_cipher got %02h/%0b want 03/0", rd_data, rd_lost); end
    rd_sel = 1'b1; #1;
    n_checks++; if (rd_data !== 8'h42 || rd_lost !== 1'b0) begin n_fail++; $display("FAIL vec_rd0_plain got %02h/%0b want 42/0", rd_data, rd_lost); end
    rd_idx = 3'd1; #1;
    n_checks++; if (rd_data !== 8'h41 || rd_lost !== 1'b0) begin n_fail++; $display("FAIL vec_rd1_plain got %02h/%0b want 41/0", rd_data, rd_lost); end
    rd_idx = 3'd2; #1;
    n_checks++; if (rd_data !== 8'h00 || rd_lost !== 1'b1) begin n_fail++; $display("FAIL vec_rd2_empty got %02h/%0b want 00/1", rd_data, rd_lost); end

    do_seed(8'h5A);
    send(8'h00, 1'b0, acc);
    n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL vec_enc5a got %02h want 5a", out_data); end
    do_seed(8'h5A);
    n_checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL vec_reseed got %0b/%0d want 0/0", out_valid, count); end
    send(8'h5A, 1'b1, acc);
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL vec_dec got %02h want 00", out_data); end
    n_checks++; if (count !== 4'd1 || wrapped !== 1'b0) begin n_fail++; $display("FAIL vec_dec_count got %0d/%0b want 1/0", count, wrapped); end
    void'(m_exp.pop_front());
    tick();
  endtask

  task automatic test_stall();
    bit acc;
    out_ready = 1'b1;
    do_seed(8'h33);
    out_ready = 1'b0;
    send(8'h10, 1'b0, acc);
    in_valid = 1'b1; in_data = 8'h77; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc%0d got %0b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h23) begin n_fail++; $display("FAIL stall_hold cyc%0d got %0b/%02h want 1/23", i, out_valid, out_data); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %0b want 1", in_ready); end
    void'(m_exp.pop_front());
    if (in_ready) model_accept(8'h77, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h54) begin n_fail++; $display("FAIL stall_next got %0b/%02h want 1/54", out_valid, out_data); end
    void'(m_exp.pop_front());
    tick();
  endtask

  task automatic test_wrap();
    bit acc;
    logic [7:0] d;
    bit lost;
    out_ready = 1'b1;
    do_seed(8'($urandom));
    for (int i = 0; i < 9; i++) begin
      send(8'($urandom), 1'b0, acc);
      if (i == 7) begin
        n_checks++; if (count !== 4'd8 || wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_full got %0d/%0b want 8/0", count, wrapped); end
      end
    end
    m_exp.delete();
    tick();
    n_checks++; if (count !== 4'd8 || wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_over got %0d/%0b want 8/1", count, wrapped); end
    rd_idx = 3'd7; rd_sel = 1'b1; #1;
    n_checks++; if (rd_data !== 8'h00 || rd_lost !== 1'b1) begin n_fail++; $display("FAIL wrap_rd7_plain got %02h/%0b want 00/1", rd_data, rd_lost); end
    rd_sel = 1'b0; #1;
    model_read(7, 1'b0, d, lost);
    n_checks++; if (rd_data !== d || rd_lost !== lost) begin n_fail++; $display("FAIL wrap_rd7_cipher got %02h/%0b want %02h/%0b", rd_data, rd_lost, d, lost); end
    rd_idx = 3'd6; rd_sel = 1'b1; #1;
    model_read(6, 1'b1, d, lost);
    n_checks++; if (rd_data !== d || rd_lost !== 1'b0) begin n_fail++; $display("FAIL wrap_rd6_plain got %02h/%0b want %02h/0", rd_data, rd_lost, d); end
  endtask

  task automatic test_seed_collision();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hC3; mode = 1'b0;
    seed = 8'h96; seed_load = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL collide_in_ready got %0b want 0", in_ready); end
    tick();
    seed_load = 1'b0; in_valid = 1'b0;
    model_reseed(8'h96);
    n_checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL collide_state got %0d/%0b want 0/0", count, out_valid); end
  endtask

  task automatic test_reset_midstream();
    bit acc;
    out_ready = 1'b1;
    do_seed(8'h21);
    out_ready = 1'b0;
    send(8'h08, 1'b0, acc);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %0b want 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL mid_rst got %0b/%0d want 0/0", out_valid, count); end
    tick();
    rst = 1'b0;
    m_run = 1'b0;
    m_exp.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_idle cyc%0d got %0b want 0", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    do_seed(8'h44);
    in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_run_ready got %0b want 1", in_ready); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit exp_ready;
    logic [7:0] d;
    bit lost;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed      = 8'($urandom);
      rd_idx    = 3'($urandom_range(0, 7));
      rd_sel    = 1'($urandom_range(0, 1));
      #1;
      exp_ready = m_run && !seed_load && (m_exp.size() == 0 || out_ready);
      n_checks++; if (out_valid !== (m_exp.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid cyc%0d got %0b want %0b", cyc, out_valid, m_exp.size() != 0); end
      if (m_exp.size() != 0) begin
        n_checks++; if (out_data !== m_exp[0]) begin n_fail++; $display("FAIL rnd_out_data cyc%0d got %02h want %02h", cyc, out_data, m_exp[0]); end
      end
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc%0d got %0b want %0b", cyc, in_ready, exp_ready); end
      n_checks++; if (count !== 4'(model_count()) || wrapped !== model_wrapped()) begin n_fail++; $display("FAIL rnd_count cyc%0d got %0d/%0b want %0d/%0b", cyc, count, wrapped, model_count(), model_wrapped()); end
      model_read(int'(rd_idx), rd_sel, d, lost);
      n_checks++; if (rd_data !== d || rd_lost !== lost) begin n_fail++; $display("FAIL rnd_read cyc%0d idx%0d sel%0b got %02h/%0b want %02h/%0b", cyc, rd_idx, rd_sel, rd_data, rd_lost, d, lost); end
      if (seed_load) begin
        model_reseed(seed);
      end else begin
        if (m_exp.size() != 0 && out_ready) void'(m_exp.pop_front());
        if (in_valid && exp_ready) model_accept(in_data, mode);
      end
      tick();
    end
    seed_load = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_wrap();
    test_seed_collision();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
